host_regbank_seg: RTL and testbench
===================================

Name: host_regbank_seg

Overview:
- Parametrised host-bus register bank and 7-segment scanner between the M1 static-memory host bus and the processing core.
- Adds the following over the current host interface:
  - synchronised host strobes with exactly one write per strobe
  - full readback
  - a command start pulse
  - a runtime-selectable hex display window
- Single clock domain. The display scan uses a clock enable, not a derived clock.

Parameters:
NUM_REGS, 24, number of 16-bit general registers at word addresses 0x00000..2*(NUM_REGS-1); legal range 1..2048
NUM_DIGITS, 6, number of 7-segment digits scanned; 1..8
SEG_DIV, 25000, clk cycles per digit advance (tick period)
CMD_ADDR, 20'h01000, command register address
STATUS_ADDR, 20'h01002, read-only status address
DISP_ADDR, 20'h01004, display control register address
RES_ADDR, 20'h02000, base of 8-word read-only result window

Ports:
clk  in  1  system clock
RESET  in  1  reset; synchronous, active-high
HOST_nCS  in  1  host chip select, active-low, asynchronous to clk
HOST_nWE  in  1  host write strobe, active-low, asynchronous
HOST_nOE  in  1  host read strobe, active-low, asynchronous
HOST_ADD  in  21  host byte address; bit 0 ignored
HDI  in  16  host write data
HDO  out  16  host read data
proc_status  in  4  core status
proc_acc_dout  in  64  core accumulator result
proc_pow_acc_dout  in  64  core power-accumulator result
regs_flat  out  NUM_REGS*16  general registers; word k at [16k+15:16k]
proc_cmd  out  4  command register bits
cmd_start  out  1  one-cycle start pulse
SEG_COM  out  NUM_DIGITS  digit enables, active-low; digit 0 at MSB
SEG_DATA  out  8  segments {a,b,c,d,e,f,g,dp}, active-high; dp always 0

Behaviour:
- Reset: all registers 0, HDO 0, proc_cmd 0, cmd_start 0, SEG_COM all ones, SEG_DATA 0, digit index 0, tick counter 0. A mid-operation reset aborts any pending write and no write is committed.
- Synchronisers: HOST_nCS, HOST_nWE and HOST_nOE each pass through 2 flops; a third flop holds the previous state.
  - wr_act = synced nCS=0 & nWE=0 & nOE=1.
  - rd_act = synced nCS=0 & nOE=0.
- Write commit: occurs on the edge where wr_act is 1 and its previous value is 0.
  - HOST_ADD and HDI are sampled at that edge.
  - Written data is visible on outputs after the 3rd rising clk edge, counting the edge that first samples the strobe low.
  - A held strobe writes exactly once; a new write needs nWE to deassert for at least 2 clk.
  - The host holds address and data stable for at least 4 clk after the strobe falls.
- Address map (HOST_ADD[20] must be 0; otherwise unmapped):
  - General registers: read/write, 0x00000..2*(NUM_REGS-1).
  - CMD_ADDR: read/write; proc_cmd <= HDI[3:0].
  - STATUS_ADDR: read only; reads {12'b0, proc_status}.
  - DISP_ADDR: read/write, 7 bits.
    - [1:0] source: 0 = acc, 1 = pow_acc, 2 = {general reg 3,2,1,0}, 3 = blank.
    - [5:2] nibble offset.
    - [6] display off.
  - RES_ADDR+0..+6: acc words, least-significant first.
  - RES_ADDR+8..+E: pow_acc words, least-significant first.
  - Unmapped reads return 0x0000; unmapped writes and writes to read-only addresses are ignored.
- cmd_start is 1 for exactly the cycle after a CMD_ADDR commit with HDI[0]=1. It is 0 otherwise, including on rewrite of the same value.
- HDO updates every cycle while rd_act=1 from the current HOST_ADD and holds its last value when rd_act=0. Read latency is 1 clk after rd_act.
- rd_act and wr_act are never both 1, since nOE gates wr_act.
- Display tick: a counter runs 0..SEG_DIV-1 and asserts tick for 1 cycle at wrap. Each tick advances the digit index, which wraps from NUM_DIGITS-1 to 0.
- On each tick, SEG_COM and SEG_DATA register digit i (the index before advance):
  - SEG_COM: only bit NUM_DIGITS-1-i is low.
  - SEG_DATA: {hex(nibble), 1'b0}, where nibble = source[4*((offset+i) mod 16) +: 4].
- If source=3 or off=1, SEG_COM is all ones and SEG_DATA is 0.
- Hex map:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- A DISP write takes effect at the next tick; there is no glitch on the current digit.

Decomposition:
- Package host_itf_pkg holds:
  - the address constants
  - display source encodings
  - the hex-to-segment function
- Sub-module seg_scan, parameterised NUM_DIGITS and SEG_DIV, contains:
  - the tick counter and digit index
  - the nibble select
  - the SEG_COM/SEG_DATA registers
- The top level holds the synchronisers, decode, register bank and read mux.

Test Plan:
- Reset: RESET=1 for 2 clk -> HDO=0, regs_flat=0, SEG_COM all ones, cmd_start=0.
- Write 0x1234 to 0x00006 and hold nWE low for 20 clk -> reg 3 = 0x1234 after 3 edges; exactly one commit; read of 0x00006 gives HDO=0x1234 1 clk after rd_act.
- Write 0x0005 to CMD_ADDR -> proc_cmd=4'h5, one cmd_start pulse; write 0x0004 -> proc_cmd=4'h4, no pulse.
- proc_acc_dout=64'h0123456789ABCDEF; read RES_ADDR..+6 -> CDEF, 89AB, 4567, 0123; STATUS read with proc_status=4'hA -> 0x000A; read 0x1FFFFE -> 0x0000.
- SEG_DIV=4, NUM_DIGITS=6, acc=64'h...ABCDEF, DISP=0 -> digit 0 shows F (1000111), SEG_COM=011111 on the first tick; digit 5 shows A. Then DISP offset=14 -> digits show nibbles 14, 15, 0, 1, ... (wrap).
- DISP bit6=1 -> SEG_COM=111111 from the next tick. RESET asserted mid-write (during synchroniser delay) -> no register changes.

Source files
------------

// File: rtl/host_itf_pkg.sv
// host_itf_pkg: host bus address map, display source encodings and hex-to-segment lookup
package host_itf_pkg;
    localparam logic [19:0] DEF_CMD_ADDR    = 20'h01000;
    localparam logic [19:0] DEF_STATUS_ADDR = 20'h01002;
    localparam logic [19:0] DEF_DISP_ADDR   = 20'h01004;
    localparam logic [19:0] DEF_RES_ADDR    = 20'h02000;

    typedef enum logic [1:0] {SRC_ACC, SRC_POW, SRC_REG, SRC_BLANK} src_e;

    // segments ordered {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction
endpackage

// File: rtl/seg_scan.sv
// seg_scan: clock-enabled multiplexed 7-segment scanner over a 64-bit nibble source
module seg_scan
    import host_itf_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SEG_DIV    = 25000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           i_src,
    input  logic [3:0]            i_off,
    input  logic                  i_blank,
    output logic [NUM_DIGITS-1:0] o_com,
    output logic [7:0]            o_data
);
    localparam int CW = $clog2(SEG_DIV + 1);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]         r_cnt;
    logic [DW-1:0]         r_dig;
    logic [NUM_DIGITS-1:0] r_com;
    logic [7:0]            r_data;
    logic                  w_tick;
    logic [3:0]            w_pos;
    logic [3:0]            w_nib;
    logic [NUM_DIGITS-1:0] w_com;

    assign w_tick = r_cnt == CW'(SEG_DIV - 1);
    // nibble position wraps modulo 16 through the 4-bit add
    assign w_pos  = i_off + 4'(r_dig);
    assign w_nib  = i_src[{w_pos, 2'b00} +: 4];
    assign w_com  = ~(NUM_DIGITS'(1) << (DW'(NUM_DIGITS - 1) - r_dig));
    assign o_com  = r_com;
    assign o_data = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dig  <= '0;
            r_com  <= '1;
            r_data <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            if (w_tick) begin
                r_dig  <= r_dig == DW'(NUM_DIGITS - 1) ? '0 : r_dig + DW'(1);
                r_com  <= i_blank ? '1 : w_com;
                r_data <= i_blank ? 8'h00 : {hex7(w_nib), 1'b0};
            end
        end
    end
endmodule

// File: rtl/host_regbank_seg.sv
// host_regbank_seg: synchronised host-bus register bank with readback, command pulse and hex display
module host_regbank_seg
    import host_itf_pkg::*;
#(
    parameter int          NUM_REGS    = 24,
    parameter int          NUM_DIGITS  = 6,
    parameter int          SEG_DIV     = 25000,
    parameter logic [19:0] CMD_ADDR    = DEF_CMD_ADDR,
    parameter logic [19:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [19:0] DISP_ADDR   = DEF_DISP_ADDR,
    parameter logic [19:0] RES_ADDR    = DEF_RES_ADDR
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     HOST_nCS,
    input  logic                     HOST_nWE,
    input  logic                     HOST_nOE,
    input  logic [20:0]              HOST_ADD,
    input  logic [15:0]              HDI,
    output logic [15:0]              HDO,
    input  logic [3:0]               proc_status,
    input  logic [63:0]              proc_acc_dout,
    input  logic [63:0]              proc_pow_acc_dout,
    output logic [NUM_REGS*16-1:0]   regs_flat,
    output logic [3:0]               proc_cmd,
    output logic                     cmd_start,
    output logic [NUM_DIGITS-1:0]    SEG_COM,
    output logic [7:0]               SEG_DATA
);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic [1:0]    r_cs, r_we, r_oe;
    logic          r_wr_prev;
    logic [15:0]   r_regs [NUM_REGS];
    logic [3:0]    r_cmd;
    logic          r_start;
    logic [6:0]    r_disp;
    logic [15:0]   r_hdo;
    logic          w_wr, w_rd, w_commit, w_map, w_gen, w_cmd, w_stat, w_disp, w_res, w_blank;
    logic [18:0]   w_a;
    logic [IW-1:0] w_idx;
    logic [63:0]   w_res64, w_regsrc, w_src;
    logic [15:0]   w_rdata;
    src_e          w_sel;
    logic          w_unused;

    assign w_wr     = ~r_cs[1] & ~r_we[1] & r_oe[1];
    assign w_rd     = ~r_cs[1] & ~r_oe[1];
    assign w_commit = w_wr & ~r_wr_prev;
    assign w_a      = HOST_ADD[19:1];
    assign w_unused = HOST_ADD[0];
    assign w_map    = ~HOST_ADD[20];
    assign w_idx    = w_a[IW-1:0];
    assign w_gen    = w_map && ({13'b0, w_a} < NUM_REGS);
    assign w_cmd    = w_map && w_a == CMD_ADDR[19:1];
    assign w_stat   = w_map && w_a == STATUS_ADDR[19:1];
    assign w_disp   = w_map && w_a == DISP_ADDR[19:1];
    assign w_res    = w_map && w_a[18:3] == RES_ADDR[19:4];
    assign w_res64  = w_a[2] ? proc_pow_acc_dout : proc_acc_dout;
    assign w_rdata  = w_gen  ? r_regs[w_idx] :
                      w_cmd  ? {12'b0, r_cmd} :
                      w_stat ? {12'b0, proc_status} :
                      w_disp ? {9'b0, r_disp} :
                      w_res  ? w_res64[{w_a[1:0], 4'b0000} +: 16] : 16'h0000;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[16*g +: 16] = r_regs[g];
    end

    // register-window display source tolerates banks with fewer than 4 registers
    for (genvar g = 0; g < 4; g++) begin : g_src
        if (g < NUM_REGS) begin : g_on
            assign w_regsrc[16*g +: 16] = r_regs[g];
        end else begin : g_off
            assign w_regsrc[16*g +: 16] = 16'h0000;
        end
    end

    assign w_sel   = src_e'(r_disp[1:0]);
    assign w_src   = w_sel == SRC_ACC ? proc_acc_dout : w_sel == SRC_POW ? proc_pow_acc_dout : w_regsrc;
    assign w_blank = r_disp[6] | (w_sel == SRC_BLANK);

    assign HDO       = r_hdo;
    assign proc_cmd  = r_cmd;
    assign cmd_start = r_start;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_cs      <= '1;
            r_we      <= '1;
            r_oe      <= '1;
            r_wr_prev <= 1'b0;
            r_regs    <= '{default: '0};
            r_cmd     <= '0;
            r_start   <= 1'b0;
            r_disp    <= '0;
            r_hdo     <= '0;
        end else begin
            r_cs      <= {r_cs[0], HOST_nCS};
            r_we      <= {r_we[0], HOST_nWE};
            r_oe      <= {r_oe[0], HOST_nOE};
            r_wr_prev <= w_wr;
            r_start   <= w_commit & w_cmd & HDI[0];
            if (w_rd) r_hdo <= w_rdata;
            if (w_commit && w_gen) r_regs[w_idx] <= HDI;
            if (w_commit && w_cmd) r_cmd <= HDI[3:0];
            if (w_commit && w_disp) r_disp <= HDI[6:0];
        end
    end

    seg_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEG_DIV    (SEG_DIV)
    ) u_scan (
        .clk     (clk),
        .rst     (RESET),
        .i_src   (w_src),
        .i_off   (r_disp[5:2]),
        .i_blank (w_blank),
        .o_com   (SEG_COM),
        .o_data  (SEG_DATA)
    );
endmodule

// File: tb/tb_host_regbank_seg.sv
// tb_host_regbank_seg: randomized host-bus and display checks against a behavioural address-map model
module tb_host_regbank_seg;
    localparam int NR = 24, ND = 6, SD = 4;

    logic              clk = 1'b0;
    logic              RESET = 1'b1;
    logic              HOST_nCS = 1'b1, HOST_nWE = 1'b1, HOST_nOE = 1'b1;
    logic [20:0]       HOST_ADD = '0;
    logic [15:0]       HDI = '0;
    logic [15:0]       HDO;
    logic [3:0]        proc_status = '0;
    logic [63:0]       proc_acc_dout = '0, proc_pow_acc_dout = '0;
    logic [NR*16-1:0]  regs_flat;
    logic [3:0]        proc_cmd;
    logic              cmd_start;
    logic [ND-1:0]     SEG_COM;
    logic [7:0]        SEG_DATA;

    int n_tests = 0, n_fail = 0, start_cnt = 0;
    logic [15:0] m_regs [NR];
    logic [3:0]  m_cmd;
    logic [6:0]  m_disp;

    host_regbank_seg #(.NUM_REGS(NR), .NUM_DIGITS(ND), .SEG_DIV(SD)) dut (
        .clk(clk), .RESET(RESET), .HOST_nCS(HOST_nCS), .HOST_nWE(HOST_nWE), .HOST_nOE(HOST_nOE),
        .HOST_ADD(HOST_ADD), .HDI(HDI), .HDO(HDO), .proc_status(proc_status),
        .proc_acc_dout(proc_acc_dout), .proc_pow_acc_dout(proc_pow_acc_dout), .regs_flat(regs_flat),
        .proc_cmd(proc_cmd), .cmd_start(cmd_start), .SEG_COM(SEG_COM), .SEG_DATA(SEG_DATA)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (cmd_start === 1'b1) start_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) m_regs[k] = '0;
        m_cmd = '0;
        m_disp = '0;
    endfunction

    function automatic void model_write(input logic [20:0] a, input logic [15:0] d);
        int b;
        if (a[20]) return;
        b = int'({a[19:1], 1'b0});
        if (b < 2 * NR) m_regs[b / 2] = d;
        else if (b == 'h1000) m_cmd = d[3:0];
        else if (b == 'h1004) m_disp = d[6:0];
    endfunction

    function automatic logic [15:0] exp_rd(input logic [20:0] a);
        int b;
        if (a[20]) return 16'h0;
        b = int'({a[19:1], 1'b0});
        if (b < 2 * NR) return m_regs[b / 2];
        if (b == 'h1000) return {12'h0, m_cmd};
        if (b == 'h1002) return {12'h0, proc_status};
        if (b == 'h1004) return {9'h0, m_disp};
        if (b >= 'h2000 && b <= 'h2006) return 16'(proc_acc_dout >> (16 * ((b - 'h2000) / 2)));
        if (b >= 'h2008 && b <= 'h200E) return 16'(proc_pow_acc_dout >> (16 * ((b - 'h2008) / 2)));
        return 16'h0;
    endfunction

    function automatic logic [NR*16-1:0] m_flat();
        logic [NR*16-1:0] r;
        for (int k = 0; k < NR; k++) r[16*k +: 16] = m_regs[k];
        return r;
    endfunction

    function automatic logic [63:0] disp_src();
        case (m_disp[1:0])
            2'd0: return proc_acc_dout;
            2'd1: return proc_pow_acc_dout;
            2'd2: return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
            default: return 64'h0;
        endcase
    endfunction

    task automatic host_write(input logic [20:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        HOST_ADD = a; HDI = d; HOST_nCS = 1'b0; HOST_nWE = 1'b0; HOST_nOE = 1'b1;
        repeat (hold) @(negedge clk);
        HOST_nWE = 1'b1; HOST_nCS = 1'b1;
        model_write(a, d);
        repeat (3) @(negedge clk);
    endtask

    task automatic host_read(input logic [20:0] a);
        @(negedge clk);
        HOST_ADD = a; HOST_nCS = 1'b0; HOST_nOE = 1'b0; HOST_nWE = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic host_idle();
        HOST_nCS = 1'b1; HOST_nOE = 1'b1; HOST_nWE = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        model_reset();
        n_tests++; if (HDO !== 16'h0) begin n_fail++; $display("FAIL reset_hdo: got %h expected 0000", HDO); end
        n_tests++; if (regs_flat !== '0) begin n_fail++; $display("FAIL reset_regs: got %h expected 0", regs_flat); end
        n_tests++; if (SEG_COM !== '1) begin n_fail++; $display("FAIL reset_segcom: got %b expected all ones", SEG_COM); end
        n_tests++; if (SEG_DATA !== 8'h0) begin n_fail++; $display("FAIL reset_segdata: got %h expected 00", SEG_DATA); end
        n_tests++; if (cmd_start !== 1'b0 || proc_cmd !== 4'h0) begin n_fail++; $display("FAIL reset_cmd: start=%b cmd=%h expected 0/0", cmd_start, proc_cmd); end
    endtask

    task automatic test_write_hold();
        @(negedge clk);
        HOST_ADD = 21'h00006; HDI = 16'h1234; HOST_nCS = 1'b0; HOST_nWE = 1'b0; HOST_nOE = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (regs_flat[48 +: 16] !== 16'h0) begin n_fail++; $display("FAIL wr_before_3rd_edge: got %h expected 0000", regs_flat[48 +: 16]); end
        @(negedge clk);
        n_tests++; if (regs_flat[48 +: 16] !== 16'h1234) begin n_fail++; $display("FAIL wr_after_3rd_edge: got %h expected 1234", regs_flat[48 +: 16]); end
        repeat (5) @(negedge clk);
        HDI = 16'hBEEF;
        repeat (12) @(negedge clk);
        HOST_nWE = 1'b1; HOST_nCS = 1'b1;
        model_write(21'h00006, 16'h1234);
        repeat (3) @(negedge clk);
        n_tests++; if (regs_flat[48 +: 16] !== 16'h1234) begin n_fail++; $display("FAIL single_commit: got %h expected 1234", regs_flat[48 +: 16]); end
        n_tests++; if (regs_flat !== m_flat()) begin n_fail++; $display("FAIL regs_flat_after_write: got %h expected %h", regs_flat, m_flat()); end
        @(negedge clk);
        HOST_ADD = 21'h00006; HOST_nCS = 1'b0; HOST_nOE = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (HDO !== 16'h0) begin n_fail++; $display("FAIL rd_latency_early: got %h expected 0000", HDO); end
        @(negedge clk);
        n_tests++; if (HDO !== 16'h1234) begin n_fail++; $display("FAIL rd_latency: got %h expected 1234", HDO); end
        host_idle();
        n_tests++; if (HDO !== 16'h1234) begin n_fail++; $display("FAIL rd_hold: got %h expected 1234", HDO); end
    endtask

    task automatic test_cmd();
        int c0;
        c0 = start_cnt;
        host_write(21'h01000, 16'h0005, 6);
        n_tests++; if (proc_cmd !== 4'h5) begin n_fail++; $display("FAIL cmd_value5: got %h expected 5", proc_cmd); end
        n_tests++; if (start_cnt - c0 != 1) begin n_fail++; $display("FAIL cmd_pulse: got %0d pulse cycles expected 1", start_cnt - c0); end
        c0 = start_cnt;
        host_write(21'h01000, 16'h0004, 6);
        n_tests++; if (proc_cmd !== 4'h4) begin n_fail++; $display("FAIL cmd_value4: got %h expected 4", proc_cmd); end
        n_tests++; if (start_cnt != c0) begin n_fail++; $display("FAIL cmd_no_pulse: got %0d pulse cycles expected 0", start_cnt - c0); end
        host_read(21'h01000);
        n_tests++; if (HDO !== 16'h0004) begin n_fail++; $display("FAIL cmd_readback: got %h expected 0004", HDO); end
        host_idle();
    endtask

    task automatic test_results();
        logic [15:0] acc_words [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        proc_acc_dout = 64'h0123456789ABCDEF;
        proc_pow_acc_dout = {$urandom, $urandom};
        proc_status = 4'hA;
        for (int k = 0; k < 4; k++) begin
            host_read(21'h02000 + 21'(2 * k));
            n_tests++; if (HDO !== acc_words[k]) begin n_fail++; $display("FAIL res_acc%0d: got %h expected %h", k, HDO, acc_words[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            host_read(21'h02008 + 21'(2 * k));
            n_tests++; if (HDO !== exp_rd(HOST_ADD)) begin n_fail++; $display("FAIL res_pow%0d: got %h expected %h", k, HDO, exp_rd(HOST_ADD)); end
        end
        host_read(21'h01002);
        n_tests++; if (HDO !== 16'h000A) begin n_fail++; $display("FAIL status: got %h expected 000A", HDO); end
        host_read(21'h1FFFFE);
        n_tests++; if (HDO !== 16'h0000) begin n_fail++; $display("FAIL unmapped_high: got %h expected 0000", HDO); end
        host_read(21'h02010);
        n_tests++; if (HDO !== 16'h0000) begin n_fail++; $display("FAIL unmapped_res_end: got %h expected 0000", HDO); end
        host_idle();
    endtask

    task automatic test_random();
        logic [20:0] a;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 21'(2 * $urandom_range(0, NR - 1)) | 21'($urandom_range(0, 1));
                3:       a = 21'h01000;
                4:       a = $urandom_range(0, 1) ? 21'h01002 : 21'h02000 + 21'(2 * $urandom_range(0, 7));
                default: a = $urandom_range(0, 1) ? (21'h100000 | 21'(2 * $urandom_range(0, NR - 1))) : 21'(2 * $urandom_range(NR, 2047));
            endcase
            host_write(a, 16'($urandom), 4 + $urandom_range(0, 3));
        end
        n_tests++; if (regs_flat !== m_flat()) begin n_fail++; $display("FAIL rand_regs: got %h expected %h", regs_flat, m_flat()); end
        n_tests++; if (proc_cmd !== m_cmd) begin n_fail++; $display("FAIL rand_cmd: got %h expected %h", proc_cmd, m_cmd); end
        proc_acc_dout = {$urandom, $urandom};
        proc_pow_acc_dout = {$urandom, $urandom};
        proc_status = 4'($urandom);
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = 21'(2 * $urandom_range(0, NR - 1));
                2:       a = 21'h01000 + 21'(2 * $urandom_range(0, 2));
                3:       a = 21'h02000 + 21'(2 * $urandom_range(0, 7));
                default: a = 21'($urandom);
            endcase
            host_read(a);
            n_tests++; if (HDO !== exp_rd(a)) begin n_fail++; $display("FAIL rand_read @%h: got %h expected %h", a, HDO, exp_rd(a)); end
        end
        host_idle();
    endtask

    task automatic track_ticks(input int n, input int first);
        logic [ND-1:0] prev;
        logic [3:0] nib;
        int cyc, last, seen, expd, dig;
        prev = SEG_COM; cyc = 0; last = -1; seen = 0; expd = first;
        while (seen < n && cyc < (n + 2) * SD) begin
            @(negedge clk);
            cyc++;
            if (SEG_COM !== prev) begin
                prev = SEG_COM;
                dig = -1;
                for (int k = 0; k < ND; k++) if (SEG_COM === ~(ND'(1) << (ND - 1 - k))) dig = k;
                n_tests++;
                if (dig < 0 || (expd >= 0 && dig != expd)) begin n_fail++; $display("FAIL seg_digit: SEG_COM=%b expected digit %0d", SEG_COM, expd); end
                if (last >= 0) begin
                    n_tests++; if (cyc - last != SD) begin n_fail++; $display("FAIL tick_period: got %0d cycles expected %0d", cyc - last, SD); end
                end
                if (dig >= 0) begin
                    nib = 4'(disp_src() >> (4 * ((int'(m_disp[5:2]) + dig) % 16)));
                    n_tests++; if (SEG_DATA !== {seg7(nib), 1'b0}) begin n_fail++; $display("FAIL seg_data digit %0d: got %b expected %b", dig, SEG_DATA, {seg7(nib), 1'b0}); end
                    expd = (dig + 1) % ND;
                end
                last = cyc;
                seen++;
            end
        end
        n_tests++; if (seen < n) begin n_fail++; $display("FAIL seg_ticks: saw %0d ticks expected %0d", seen, n); end
    endtask

    task automatic test_display();
        int cyc;
        proc_acc_dout = 64'h0123456789ABCDEF;
        do_reset();
        cyc = 0;
        while (SEG_COM === '1 && cyc < 2 * SD) begin @(negedge clk); cyc++; end
        n_tests++; if (SEG_COM !== 6'b011111) begin n_fail++; $display("FAIL first_tick_com: got %b expected 011111", SEG_COM); end
        n_tests++; if (SEG_DATA !== 8'b10001110) begin n_fail++; $display("FAIL first_tick_data: got %b expected 10001110", SEG_DATA); end
        track_ticks(7, 1);
        host_write(21'h01004, 16'(14 << 2), 5);
        track_ticks(8, -1);
        for (int k = 0; k < 4; k++) host_write(21'(2 * k), 16'($urandom), 4);
        host_write(21'h01004, 16'h0002 | 16'($urandom_range(0, 15) << 2), 5);
        track_ticks(8, -1);
        proc_pow_acc_dout = {$urandom, $urandom};
        host_write(21'h01004, 16'h0001 | 16'($urandom_range(0, 15) << 2), 5);
        track_ticks(6, -1);
    endtask

    task automatic test_display_off();
        host_write(21'h01004, 16'h0040, 4);
        repeat (2 * SD) @(negedge clk);
        n_tests++; if (SEG_COM !== '1 || SEG_DATA !== 8'h0) begin n_fail++; $display("FAIL display_off: com=%b data=%h expected all ones/00", SEG_COM, SEG_DATA); end
        host_write(21'h01004, 16'h0000, 4);
        track_ticks(2, -1);
        host_write(21'h01004, 16'h0003, 4);
        repeat (2 * SD) @(negedge clk);
        n_tests++; if (SEG_COM !== '1 || SEG_DATA !== 8'h0) begin n_fail++; $display("FAIL display_blank_src: com=%b data=%h expected all ones/00", SEG_COM, SEG_DATA); end
    endtask

    task automatic test_reset_midwrite();
        host_write(21'h00002, 16'h7777, 4);
        @(negedge clk);
        HOST_ADD = 21'h0000A; HDI = 16'h5A5A; HOST_nCS = 1'b0; HOST_nWE = 1'b0; HOST_nOE = 1'b1;
        @(negedge clk);
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        HOST_nWE = 1'b1; HOST_nCS = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        n_tests++; if (regs_flat[80 +: 16] !== 16'h0) begin n_fail++; $display("FAIL midwrite_reg5: got %h expected 0000", regs_flat[80 +: 16]); end
        n_tests++; if (regs_flat !== m_flat()) begin n_fail++; $display("FAIL midwrite_regs: got %h expected %h", regs_flat, m_flat()); end
    endtask

    initial begin
        test_reset();
        test_write_hold();
        test_cmd();
        test_results();
        test_random();
        test_display();
        test_display_off();
        test_reset_midwrite();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
